seq_stream_ctrl: RTL and testbench

- Sequencer in front of the serial sequence detectors (mealy/moore style; ports flag, seq, clk, rst).
- Loads a parallel test word and streams it LSB-first, one bit per clock, onto the detector's seq input.
- Holds the detector in reset between runs, samples its flag, and reports hit count, first-hit index and completion.
- Replaces hand-written shift loops in benches and lets a host drive the detector on-chip.

---
 rtl/seq_ctrl_pkg.sv | 21 ++
 rtl/seq_ctrl_shifter.sv | 43 ++++
 rtl/seq_stream_ctrl.sv | 145 ++++++++++++++
 tb/tb_seq_stream_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_ctrl_pkg.sv
// Shared types and defaults for the detector stream sequencer.
// Build option SEQ_CTRL_HIT_LOG_EN adds a per-index hit mask output to seq_stream_ctrl.
package seq_ctrl_pkg;

   localparam int DEF_DATA_W   = 20;
   localparam int DEF_CNT_W    = 5;
   localparam int DEF_FLAG_LAT = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   // A zero or oversized request means "send the whole word".
   function automatic int unsigned clamp_len(input int unsigned req, input int unsigned max_len);
      return ((req == 0) || (req > max_len)) ? max_len : req;
   endfunction

endpackage

// File: rtl/seq_ctrl_shifter.sv
// Parallel-load, LSB-first shift register with a running bit index.
module seq_ctrl_shifter #(
   parameter int DATA_W = 20,
   parameter int IDX_W  = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              shift,
   input  logic [DATA_W-1:0] data_in,
   output logic              bit_out,
   output logic [IDX_W-1:0]  bit_idx
);

   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [IDX_W-1:0]  idx_q, idx_d;

   always_comb begin
      shreg_d = shreg_q;
      idx_d   = idx_q;
      if (load) begin
         shreg_d = data_in;
         idx_d   = '0;
      end else if (shift) begin
         shreg_d = {1'b0, shreg_q[DATA_W-1:1]};
         idx_d   = idx_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shreg_q <= '0;
         idx_q   <= '0;
      end else begin
         shreg_q <= shreg_d;
         idx_q   <= idx_d;
      end
   end

   assign bit_out = shreg_q[0];
   assign bit_idx = idx_q;

endmodule

// File: rtl/seq_stream_ctrl.sv
// Streams a parallel word into a serial sequence detector and tallies its flags.
// Define SEQ_CTRL_HIT_LOG_EN to add the hit_mask output.
module seq_stream_ctrl
   import seq_ctrl_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int CNT_W    = DEF_CNT_W,
   parameter int FLAG_LAT = DEF_FLAG_LAT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] data_in,
   input  logic [CNT_W-1:0]  len,
   output logic              seq_out,
   output logic              seq_vld,
   output logic              det_rst,
   input  logic              flag_in,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  hit_cnt,
   output logic [CNT_W-1:0]  first_hit,
   output logic              first_vld
`ifdef SEQ_CTRL_HIT_LOG_EN
   ,
   output logic [DATA_W-1:0] hit_mask
`endif
);

   // One extra index bit so len + FLAG_LAT never wraps.
   localparam int IDX_W = CNT_W + 1;
   localparam logic [IDX_W-1:0] LAT_V = IDX_W'(FLAG_LAT);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  len_q, len_d;
   logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
   logic [CNT_W-1:0]  first_hit_q, first_hit_d;
   logic              first_vld_q, first_vld_d;

   logic              load, active, shift_bit, attr_ok, hit;
   logic [IDX_W-1:0]  bit_idx, len_ext;
   logic [CNT_W-1:0]  len_clamped, attr_idx;
   logic              run_last, drain_last;

   assign active      = (state_q == RUN) || (state_q == DRAIN);
   assign load        = (state_q == IDLE) && start;
   assign len_clamped = CNT_W'(clamp_len(32'(len), DATA_W));
   assign len_ext     = {1'b0, len_q};
   assign run_last    = (bit_idx == len_ext - IDX_W'(1));
   assign drain_last  = (bit_idx == len_ext + LAT_V - IDX_W'(1));
   assign attr_idx    = CNT_W'(bit_idx - LAT_V);

   // Flags that arrive before the first FLAG_LAT bits cannot belong to this run.
   if (FLAG_LAT == 0) begin : g_no_lat
      assign attr_ok = 1'b1;
   end else begin : g_lat
      assign attr_ok = (bit_idx >= LAT_V);
   end

   assign hit = active && flag_in && attr_ok;

   seq_ctrl_shifter #(
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) u_shifter (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .shift   (active),
      .data_in (data_in),
      .bit_out (shift_bit),
      .bit_idx (bit_idx)
   );

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      hit_cnt_d   = hit_cnt_q;
      first_hit_d = first_hit_q;
      first_vld_d = first_vld_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = RUN;
               len_d       = len_clamped;
               hit_cnt_d   = '0;
               first_hit_d = '0;
               first_vld_d = 1'b0;
            end
         end
         RUN:     if (run_last) state_d = (FLAG_LAT > 0) ? DRAIN : DONE;
         DRAIN:   if (drain_last) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (hit) begin
         if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
         if (!first_vld_q) begin
            first_hit_d = attr_idx;
            first_vld_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         len_q       <= '0;
         hit_cnt_q   <= '0;
         first_hit_q <= '0;
         first_vld_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         hit_cnt_q   <= hit_cnt_d;
         first_hit_q <= first_hit_d;
         first_vld_q <= first_vld_d;
      end
   end

`ifdef SEQ_CTRL_HIT_LOG_EN
   logic [DATA_W-1:0] hit_mask_q, hit_mask_d;

   for (genvar gi = 0; gi < DATA_W; gi++) begin : g_mask
      assign hit_mask_d[gi] = !load && (hit_mask_q[gi] || (hit && (attr_idx == CNT_W'(gi))));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) hit_mask_q <= '0;
      else      hit_mask_q <= hit_mask_d;
   end

   assign hit_mask = hit_mask_q;
`endif

   assign seq_vld   = (state_q == RUN);
   assign seq_out   = seq_vld && shift_bit;
   assign det_rst   = active;
   assign busy      = active;
   assign done      = (state_q == DONE);
   assign hit_cnt   = hit_cnt_q;
   assign first_hit = first_hit_q;
   assign first_vld = first_vld_q;

endmodule

// File: tb/tb_seq_stream_ctrl.sv
// Bench: two controllers (mealy-style and moore-style detector models) checked against a "101" reference.
module tb_seq_stream_ctrl;

   localparam int DATA_W = 20;
   localparam int CNT_W  = 5;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [DATA_W-1:0] data_in = '0;
   logic [CNT_W-1:0]  len = '0;

   logic seq_out0, seq_vld0, det_rst0, busy0, done0, first_vld0, flag0;
   logic seq_out1, seq_vld1, det_rst1, busy1, done1, first_vld1, flag1;
   logic [CNT_W-1:0] hit_cnt0, first_hit0, hit_cnt1, first_hit1;
`ifdef SEQ_CTRL_HIT_LOG_EN
   logic [DATA_W-1:0] hit_mask0, hit_mask1;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   seq_stream_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W), .FLAG_LAT(0)) u_dut0 (
      .clk(clk), .rst(rst), .start(start), .data_in(data_in), .len(len),
      .seq_out(seq_out0), .seq_vld(seq_vld0), .det_rst(det_rst0), .flag_in(flag0),
      .busy(busy0), .done(done0), .hit_cnt(hit_cnt0), .first_hit(first_hit0),
      .first_vld(first_vld0)
`ifdef SEQ_CTRL_HIT_LOG_EN
      , .hit_mask(hit_mask0)
`endif
   );

   seq_stream_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W), .FLAG_LAT(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start), .data_in(data_in), .len(len),
      .seq_out(seq_out1), .seq_vld(seq_vld1), .det_rst(det_rst1), .flag_in(flag1),
      .busy(busy1), .done(done1), .hit_cnt(hit_cnt1), .first_hit(first_hit1),
      .first_vld(first_vld1)
`ifdef SEQ_CTRL_HIT_LOG_EN
      , .hit_mask(hit_mask1)
`endif
   );

   // Detector models: overlapping "101"; instance 1 sees the flag one cycle late.
   logic h1_0 = 1'b0, h2_0 = 1'b0, h1_1 = 1'b0, h2_1 = 1'b0, flag1_q = 1'b0;
   logic mflag1;

   always @(posedge clk) begin
      if (!det_rst0) begin
         h1_0 <= 1'b0;
         h2_0 <= 1'b0;
      end else if (seq_vld0) begin
         h1_0 <= seq_out0;
         h2_0 <= h1_0;
      end
      if (!det_rst1) begin
         h1_1    <= 1'b0;
         h2_1    <= 1'b0;
         flag1_q <= 1'b0;
      end else begin
         flag1_q <= mflag1;
         if (seq_vld1) begin
            h1_1 <= seq_out1;
            h2_1 <= h1_1;
         end
      end
   end

   assign flag0  = seq_vld0 & seq_out0 & ~h1_0 & h2_0;
   assign mflag1 = seq_vld1 & seq_out1 & ~h1_1 & h2_1;
   assign flag1  = flag1_q;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: scan the stream bits for "1,0,1" ending at index i.
   task automatic ref_model(input logic [DATA_W-1:0] d, input int ln, output int eff,
                            output int hits, output int first, output logic [DATA_W-1:0] mask);
      eff   = (ln == 0 || ln > DATA_W) ? DATA_W : ln;
      hits  = 0;
      first = 0;
      mask  = '0;
      for (int i = 2; i < eff; i++) begin
         if (d[i] && !d[i-1] && d[i-2]) begin
            if (hits == 0) first = i;
            hits++;
            mask[i] = 1'b1;
         end
      end
      if (hits > (2**CNT_W) - 1) hits = (2**CNT_W) - 1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_outs0"}, {seq_out0, seq_vld0, det_rst0, busy0, done0, first_vld0, hit_cnt0, first_hit0}, 0);
      check({tag, "_outs1"}, {seq_out1, seq_vld1, det_rst1, busy1, done1, first_vld1, hit_cnt1, first_hit1}, 0);
`ifdef SEQ_CTRL_HIT_LOG_EN
      check({tag, "_mask"}, {12'd0, hit_mask0 | hit_mask1}, 0);
`endif
   endtask

   // inject: 0 none, 1 extra start pulse in RUN cycle 3, 2 reset in RUN cycle 10
   task automatic run_case(input logic [DATA_W-1:0] d, input logic [CNT_W-1:0] ln, input int inject);
      int eff, hits, first;
      logic [DATA_W-1:0] emask;
      int vld0, vld1, done_c0, done_c1, ndone0, ndone1;
      ref_model(d, int'(ln), eff, hits, first, emask);
      vld0 = 0; vld1 = 0; done_c0 = -1; done_c1 = -1; ndone0 = 0; ndone1 = 0;

      @(negedge clk);
      check("det_rst_idle", {det_rst0, det_rst1}, 0);
      data_in = d;
      len     = ln;
      start   = 1'b1;
      @(posedge clk);
      #1;
      start   = 1'b0;
      data_in = DATA_W'($urandom);
      len     = CNT_W'($urandom);

      for (int c = 0; c < eff + 4; c++) begin
         @(negedge clk);
         if (inject == 1 && c == 3) start = 1'b1;
         if (inject == 1 && c == 4) start = 1'b0;
         if (inject == 2 && c == 10) begin
            rst = 1'b0;
            #1;
            check_all_zero("rst_midrun");
            repeat (3) begin
               @(negedge clk);
               check("done_in_rst", {done0, done1}, 0);
            end
            rst = 1'b1;
            $display("run data=%05h len=%0d aborted by reset at cycle 10", d, ln);
            return;
         end
         if (seq_vld0) begin
            if (vld0 < eff) check("seq_bit0", seq_out0, d[vld0]);
            vld0++;
         end
         if (seq_vld1) begin
            if (vld1 < eff) check("seq_bit1", seq_out1, d[vld1]);
            vld1++;
         end
         check("busy0", busy0, c < eff);
         check("det_rst0", det_rst0, c < eff);
         check("busy1", busy1, c < eff + 1);
         if (done0) begin ndone0++; done_c0 = c; end
         if (done1) begin ndone1++; done_c1 = c; end
      end

      check("vld_cnt0", vld0, eff);
      check("vld_cnt1", vld1, eff);
      check("done_at0", done_c0, eff);
      check("done_at1", done_c1, eff + 1);
      check("done_pulses0", ndone0, 1);
      check("done_pulses1", ndone1, 1);
      check("hit_cnt0", hit_cnt0, hits);
      check("hit_cnt1", hit_cnt1, hits);
      check("first_vld0", first_vld0, hits > 0);
      check("first_vld1", first_vld1, hits > 0);
      check("first_hit0", first_hit0, first);
      check("first_hit1", first_hit1, first);
`ifdef SEQ_CTRL_HIT_LOG_EN
      check("hit_mask0", hit_mask0, emask);
      check("hit_mask1", hit_mask1, emask);
`endif
      $display("run data=%05h len=%0d eff=%0d hits=%0d/%0d first=%0d done@%0d/%0d",
               d, ln, eff, hit_cnt0, hit_cnt1, first_hit0, done_c0, done_c1);
   endtask

   initial begin
      #2 rst = 1'b0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b1;
      repeat (2) @(negedge clk);

      run_case(20'h5B6B4, 5'd0, 0);
      check("spec_hits0", hit_cnt0, 6);
      check("spec_first1", first_hit1, 4);
`ifdef SEQ_CTRL_HIT_LOG_EN
      check("spec_mask0", hit_mask0, 32'h49290);
`endif
      run_case(20'h00000, 5'd0, 0);
      run_case(20'h5B6B4, 5'd5, 0);
      check("spec_len5_hits", hit_cnt0, 1);
      check("spec_len5_first", first_hit0, 4);
      run_case(20'h5B6B4, 5'd1, 0);
      run_case(20'hFFFFF, 5'd25, 0);
      run_case(20'h5B6B4, 5'd0, 1);
      run_case(20'h5B6B4, 5'd0, 2);
      run_case(20'h5B6B4, 5'd0, 0);
      for (int n = 0; n < 24; n++) begin
         run_case(DATA_W'($urandom), CNT_W'($urandom_range(0, 31)), 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
